// File: rtl/crate_write_arbiter_if.sv
// Bundled request/grant lines plus write-master control and FIFO signals
// shared between the crate write arbiter and its environment.
interface crate_write_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [5*NREQ-1:0] req_module;
  logic [2*NREQ-1:0] req_port;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic              busy;
  logic              control_fixed;
  logic              control_go;
  logic [31:0]       control_write_base;
  logic [31:0]       control_write_length;
  logic              control_done;
  logic [31:0]       user_buffer_input;
  logic              user_write_buffer;
  logic              user_buffer_full;

  modport slave (
    input  req, req_module, req_port, req_data, control_done, user_buffer_full,
    output grant, ack, err, busy, control_fixed, control_go,
           control_write_base, control_write_length,
           user_buffer_input, user_write_buffer
  );

  modport master (
    output req, req_module, req_port, req_data, control_done, user_buffer_full,
    input  grant, ack, err, busy, control_fixed, control_go,
           control_write_base, control_write_length,
           user_buffer_input, user_write_buffer
  );
endinterface

// File: rtl/crate_write_arbiter.sv
// Round-robin arbiter that pushes one requester's module/port/data triple into
// a write-master FIFO, kicks the master and waits (bounded) for completion.
//
// state       | meaning
// S_IDLE      | no transfer; arbitrate among pending requests
// S_W_ADDR    | offering module address word to the FIFO
// S_W_PORT    | offering port number word to the FIFO
// S_W_DATA    | offering data byte word to the FIFO
// S_WAIT_DONE | waiting for control_done, timeout counter running
// S_ACK       | one-cycle completion acknowledge to the owner
module crate_write_arbiter #(
  parameter int          NREQ      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h10004000,
  parameter logic [31:0] XFER_LEN  = 32'd12,
  parameter int          TIMEOUT   = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  crate_write_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_ADDR,
    S_W_PORT,
    S_W_DATA,
    S_WAIT_DONE,
    S_ACK
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_owner;
  logic [4:0]      r_module;
  logic [1:0]      r_port;
  logic [7:0]      r_data;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_ack;
  logic            r_err;
  logic            r_busy;
  logic            r_go;
  logic            r_wbuf;
  logic [31:0]     r_bufin;

  state_t          w_state_nxt;
  logic [PW-1:0]   w_rr_nxt;
  logic [PW-1:0]   w_owner_nxt;
  logic [4:0]      w_module_nxt;
  logic [1:0]      w_port_nxt;
  logic [7:0]      w_data_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [NREQ-1:0] w_grant_nxt;
  logic [NREQ-1:0] w_ack_nxt;
  logic            w_err_nxt;
  logic            w_go_nxt;
  logic            w_wbuf_nxt;
  logic [31:0]     w_bufin_nxt;

  logic            w_any_req;
  logic [PW-1:0]   w_winner;
  logic            w_accept;

  // Walk offsets from the far end down so the nearest set bit at or above
  // the pointer is the last (winning) assignment.
  always_comb begin
    w_any_req = |bus.req;
    w_winner  = r_rr_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[r_rr_ptr + PW'(i)]) begin
        w_winner = r_rr_ptr + PW'(i);
      end
    end
  end

  assign w_accept = r_wbuf & ~bus.user_buffer_full;

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_nxt     = r_rr_ptr;
    w_owner_nxt  = r_owner;
    w_module_nxt = r_module;
    w_port_nxt   = r_port;
    w_data_nxt   = r_data;
    w_cnt_nxt    = r_cnt;
    w_grant_nxt  = '0;
    w_ack_nxt    = '0;
    w_err_nxt    = 1'b0;
    w_go_nxt     = 1'b0;
    w_wbuf_nxt   = r_wbuf;
    w_bufin_nxt  = r_bufin;

    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt  = S_W_ADDR;
          w_owner_nxt  = w_winner;
          w_rr_nxt     = w_winner + PW'(1);
          w_module_nxt = bus.req_module[5*w_winner +: 5];
          w_port_nxt   = bus.req_port[2*w_winner +: 2];
          w_data_nxt   = bus.req_data[8*w_winner +: 8];
          w_grant_nxt  = NREQ'(1) << w_winner;
          w_go_nxt     = 1'b1;
          w_wbuf_nxt   = 1'b1;
          w_bufin_nxt  = 32'(bus.req_module[5*w_winner +: 5]);
        end
      end

      S_W_ADDR: begin
        if (w_accept) begin
          w_state_nxt = S_W_PORT;
          w_bufin_nxt = 32'(r_port);
        end
      end

      S_W_PORT: begin
        if (w_accept) begin
          w_state_nxt = S_W_DATA;
          w_bufin_nxt = 32'(r_data);
        end
      end

      S_W_DATA: begin
        if (w_accept) begin
          w_state_nxt = S_WAIT_DONE;
          w_wbuf_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end
      end

      // A done arriving on the final counted cycle still wins over the timeout.
      S_WAIT_DONE: begin
        if (bus.control_done) begin
          w_state_nxt = S_ACK;
          w_ack_nxt   = NREQ'(1) << r_owner;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_ACK: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_wbuf_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_module <= '0;
      r_port   <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_grant  <= '0;
      r_ack    <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_go     <= 1'b0;
      r_wbuf   <= 1'b0;
      r_bufin  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
      r_module <= w_module_nxt;
      r_port   <= w_port_nxt;
      r_data   <= w_data_nxt;
      r_cnt    <= w_cnt_nxt;
      r_grant  <= w_grant_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_go     <= w_go_nxt;
      r_wbuf   <= w_wbuf_nxt;
      r_bufin  <= w_bufin_nxt;
    end
  end

  assign bus.grant                = r_grant;
  assign bus.ack                  = r_ack;
  assign bus.err                  = r_err;
  assign bus.busy                 = r_busy;
  assign bus.control_go           = r_go;
  assign bus.control_fixed        = 1'b0;
  assign bus.control_write_base   = BASE_ADDR;
  assign bus.control_write_length = XFER_LEN;
  assign bus.user_write_buffer    = r_wbuf;
  assign bus.user_buffer_input    = r_bufin;

endmodule

// File: tb/tb_crate_write_arbiter.sv
// Scoreboard bench for crate_write_arbiter: a transaction-level model queues
// expected grants, FIFO words and outcomes; a negedge monitor checks them.
module tb_crate_write_arbiter;

  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h10004000;
  localparam logic [31:0] LEN  = 32'd12;

  typedef struct {
    bit is_err;
    int d;
    int owner;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  crate_write_arbiter_if #(.NREQ(4)) ifc ();

  crate_write_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_grant[$];
  logic [31:0] exp_word[$];
  out_t        exp_out[$];
  int          m_ptr = 0;

  logic [4:0] pm[4];
  logic [1:0] pp[4];
  logic [7:0] pd[4];

  int          acc = 0;
  int          acc3_cyc = 0;
  bit          out_seen = 0;
  int          out_cyc = 0;
  int          grant_cyc = 0;
  int          last_grant = -1;
  int          glog[$];
  bit          stall_prev = 0;
  logic [31:0] stall_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic bail(input string name);
    fail_now(name);
    finish_test();
  endtask

  task automatic put_payload();
    for (int i = 0; i < 4; i++) begin
      ifc.req_module[5*i +: 5] = pm[i];
      ifc.req_port[2*i +: 2]   = pp[i];
      ifc.req_data[8*i +: 8]   = pd[i];
    end
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 4; i++) begin
      pm[i] = 5'($urandom);
      pp[i] = 2'($urandom);
      pd[i] = 8'($urandom);
    end
  endtask

  // Reference: first requester at or after the pointer wins; the winner's
  // three fields are written in order; d==0 means done never comes.
  task automatic model_issue(input logic [3:0] rq, input int d, output int w);
    out_t o;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      if (w < 0 && rq[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    end
    m_ptr = (w + 1) % 4;
    exp_grant.push_back(w);
    exp_word.push_back({27'd0, pm[w]});
    exp_word.push_back({30'd0, pp[w]});
    exp_word.push_back({24'd0, pd[w]});
    o.is_err = (d == 0);
    o.d      = d;
    o.owner  = w;
    exp_out.push_back(o);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (ifc.grant != 0) begin
        int gi;
        gi = -1;
        chk("grant_onehot", 32'($onehot(ifc.grant)), 32'd1);
        chk("go_with_grant", 32'(ifc.control_go), 32'd1);
        for (int i = 0; i < 4; i++) if (ifc.grant[i]) gi = i;
        if (exp_grant.size() == 0) fail_now("unexpected_grant");
        else chk("grant_owner", 32'(ifc.grant), 32'd1 << exp_grant.pop_front());
        last_grant = gi;
        grant_cyc  = cyc;
        glog.push_back(gi);
      end else if (ifc.control_go) begin
        fail_now("go_without_grant");
      end

      if (stall_prev && ifc.user_write_buffer)
        chk("stall_hold", ifc.user_buffer_input, stall_val);
      stall_prev = ifc.user_write_buffer && ifc.user_buffer_full;
      stall_val  = ifc.user_buffer_input;

      if (ifc.user_write_buffer && !ifc.user_buffer_full) begin
        if (exp_word.size() == 0) fail_now("extra_fifo_word");
        else chk("fifo_word", ifc.user_buffer_input, exp_word.pop_front());
        acc++;
        if (acc == 3) acc3_cyc = cyc;
      end

      if (ifc.ack != 0 || ifc.err) begin
        chk("ack_err_exclusive", 32'((ifc.ack != 0) && ifc.err), 32'd0);
        if (exp_out.size() == 0) begin
          fail_now("unexpected_outcome");
        end else begin
          out_t o;
          o = exp_out.pop_front();
          chk("outcome_err", 32'(ifc.err), 32'(o.is_err));
          chk("outcome_ack", 32'(ifc.ack), o.is_err ? 32'd0 : (32'd1 << o.owner));
          chk("outcome_cycle", 32'(cyc), 32'(acc3_cyc + 1 + (o.is_err ? TO : o.d)));
          if (o.is_err) chk("busy_after_err", 32'(ifc.busy), 32'd0);
        end
        out_seen = 1;
        out_cyc  = cyc;
      end
    end
  end

  task automatic wait_acc(input int n);
    int t;
    t = 0;
    while (acc < n) begin
      @(posedge clk); #1;
      t++;
      if (t > 200) bail("word_accept_timeout");
    end
  endtask

  task automatic wait_grant();
    int t;
    t = 0;
    while (ifc.grant == 0) begin
      @(posedge clk); #1;
      t++;
      if (t > 40) bail("grant_timeout");
    end
  endtask

  // drop_mode: 0 = release req at grant, 1 = release in WAIT_DONE, 2 = keep holding
  task automatic run_txn(input logic [3:0] rq, input int drop_mode, input int d,
                         input int stall_word, input int stall_len);
    int w;
    int t;
    acc      = 0;
    out_seen = 0;
    put_payload();
    ifc.req = rq;
    model_issue(rq, d, w);
    wait_grant();
    if (drop_mode == 0) begin
      ifc.req = '0;
      rand_payload();
      put_payload();
    end
    if (stall_word >= 0) begin
      wait_acc(stall_word);
      ifc.user_buffer_full = 1'b1;
      ifc.control_done     = 1'b1;
      repeat (stall_len) begin @(posedge clk); #1; end
      ifc.user_buffer_full = 1'b0;
      ifc.control_done     = 1'b0;
    end
    wait_acc(3);
    if (drop_mode == 1) ifc.req = '0;
    if (d > 0) begin
      while (cyc < acc3_cyc + d) begin @(posedge clk); #1; end
      ifc.control_done = 1'b1;
      @(posedge clk); #1;
      ifc.control_done = 1'b0;
    end
    t = 0;
    while (!out_seen) begin
      @(posedge clk); #1;
      t++;
      if (t > TO + 40) bail("outcome_timeout");
    end
    chk("words_written", 32'(acc), 32'd3);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(ifc.grant), 32'd0);
    chk({tag, "_ack"}, 32'(ifc.ack), 32'd0);
    chk({tag, "_err"}, 32'(ifc.err), 32'd0);
    chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    chk({tag, "_go"}, 32'(ifc.control_go), 32'd0);
    chk({tag, "_wbuf"}, 32'(ifc.user_write_buffer), 32'd0);
    chk({tag, "_bufin"}, ifc.user_buffer_input, 32'd0);
  endtask

  initial begin
    int exp_order[5];
    int w;
    exp_order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    ifc.req = '0;
    ifc.req_module = '0;
    ifc.req_port = '0;
    ifc.req_data = '0;
    ifc.control_done = 1'b0;
    ifc.user_buffer_full = 1'b0;
    #2;
    check_all_zero("reset");
    chk("control_fixed", 32'(ifc.control_fixed), 32'd0);
    chk("write_base", ifc.control_write_base, BASE);
    chk("write_length", ifc.control_write_length, LEN);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // fairness with all requests held continuously
    rand_payload();
    glog.delete();
    for (int k = 0; k < 5; k++) run_txn(4'b1111, (k == 4) ? 1 : 2, 1, -1, 0);
    for (int k = 0; k < 5; k++) chk("fair_order", 32'(glog[k]), 32'(exp_order[k]));

    // single request, known payload, minimum latency
    pm[0] = 5'd1; pp[0] = 2'd2; pd[0] = 8'hA5;
    run_txn(4'b0001, 0, 1, -1, 0);
    chk("min_latency", 32'(out_cyc - grant_cyc), 32'd4);

    // backpressure during the port word, with a stray done that must be ignored
    rand_payload();
    run_txn(4'b0010, 0, 2, 1, 7);

    // timeout, then done landing on the last counted cycle
    rand_payload();
    run_txn(4'b1000, 0, 0, -1, 0);
    rand_payload();
    run_txn(4'b0100, 0, TO, -1, 0);

    // reset while the data word is being offered
    rand_payload();
    acc = 0;
    out_seen = 0;
    put_payload();
    ifc.req = 4'b0100;
    model_issue(4'b0100, 1, w);
    wait_grant();
    ifc.req = '0;
    wait_acc(2);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_grant.delete();
    exp_word.delete();
    exp_out.delete();
    m_ptr = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_payload();
    run_txn(4'b1111, 0, 1, -1, 0);
    chk("post_reset_grant", 32'(last_grant), 32'd0);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      int d;
      int sw;
      rand_payload();
      d  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
      sw = int'($urandom_range(0, 3));
      run_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 1)), d,
              (sw == 3) ? -1 : sw, int'($urandom_range(1, 6)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("queues_drained", 32'(exp_grant.size() + exp_word.size() + exp_out.size()), 32'd0);
    finish_test();
  end

endmodule
